// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared encodings, register offsets and byte-merge helper for tc_timer
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int EN_B     = 0;
    localparam int MODE_LSB = 1;
    localparam int IM_B     = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    function automatic logic [31:0] merge(input logic [31:0] cur,
                                          input logic [31:0] wr,
                                          input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wr[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tc_timer.sv
// rtl/tc_timer.sv - memory-mapped down-counting timer with one-shot/auto-reload modes and maskable irq
module tc_timer
    import tc_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        hit;
    logic [1:0]  off;
    logic        wr_any, wr_ctrl, wr_preset;
    logic [3:0]  ctrl_wr_val;
    logic        en, auto_reload;
    logic        set_flag, fsm_clr_flag, bus_clr_flag, fsm_clr_en;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, addr[1:0]};

    always_comb begin
        hit         = (addr[31:4] == BASE[31:4]);
        off         = addr[3:2];
        wr_any      = hit && (byteen != 4'd0);
        wr_ctrl     = wr_any && (off == OFF_CTRL);
        wr_preset   = wr_any && (off == OFF_PRESET);
        // Every stored CTRL bit lives in byte 0.
        ctrl_wr_val = byteen[0] ? wdata[3:0] : ctrl_q;
        en          = ctrl_q[EN_B];
        auto_reload = (ctrl_q[MODE_LSB +: 2] == MODE_RELOAD);
    end

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (off)
                OFF_CTRL:   rdata = {28'd0, ctrl_q};
                OFF_PRESET: rdata = preset_q;
                OFF_COUNT:  rdata = count_q;
                default:    rdata = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        set_flag     = 1'b0;
        fsm_clr_flag = 1'b0;
        fsm_clr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = 32'd0;
                    set_flag = 1'b1;
                    state_d  = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    fsm_clr_flag = 1'b1;
                    state_d      = ST_LOAD;
                end else begin
                    fsm_clr_en = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (fsm_clr_en) begin
            ctrl_d[EN_B] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = ctrl_wr_val;
        end
        preset_d = wr_preset ? merge(preset_q, wdata, byteen) : preset_q;

        // A CTRL write that only unmasks (IM=1, EN=0) leaves a pending one-shot flag visible.
        bus_clr_flag = wr_preset || (wr_ctrl && !(ctrl_wr_val[IM_B] && !ctrl_wr_val[EN_B]));
        flag_d = flag_q;
        if (bus_clr_flag || fsm_clr_flag) begin
            flag_d = 1'b0;
        end
        if (set_flag) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    assign irq = flag_q & ctrl_q[IM_B];

endmodule

// File: tb/tb_tc_timer.sv
// tb/tb_tc_timer.sv - directed table-driven and sequence checks for tc_timer
module tb_tc_timer;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSV    = 32'h0000_7F0C;
    localparam logic [31:0] A_OUT    = 32'h0000_7F10;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    tc_timer #(.BASE(32'h0000_7F00)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the write edge.
    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr   = a;
        byteen = be;
        wdata  = d;
        @(negedge clk);
        byteen = 4'd0;
        wdata  = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(name, v, exp);
    endtask

    initial begin
        logic [31:0] exp_cnt;

        vecs[0]  = '{A_PRESET, 4'b1111, 32'h0000_0000, A_PRESET, 32'h0000_0000};
        vecs[1]  = '{A_PRESET, 4'b1100, 32'hAABB_CCDD, A_PRESET, 32'hAABB_0000};
        vecs[2]  = '{A_PRESET, 4'b0011, 32'h1111_2222, A_PRESET, 32'hAABB_2222};
        vecs[3]  = '{A_PRESET, 4'b0000, 32'hFFFF_FFFF, A_PRESET, 32'hAABB_2222};
        vecs[4]  = '{A_COUNT,  4'b1111, 32'hDEAD_BEEF, A_COUNT,  32'h0000_0000};
        vecs[5]  = '{A_RSV,    4'b1111, 32'hDEAD_BEEF, A_RSV,    32'h0000_0000};
        vecs[6]  = '{A_OUT,    4'b1111, 32'h0000_000F, A_CTRL,   32'h0000_0000};
        vecs[7]  = '{A_OUT,    4'b0000, 32'h0000_0000, A_OUT,    32'h0000_0000};
        vecs[8]  = '{A_CTRL,   4'b0010, 32'h0000_0F00, A_CTRL,   32'h0000_0000};
        vecs[9]  = '{A_CTRL,   4'b0001, 32'hFFFF_FF06, A_CTRL,   32'h0000_0006};
        vecs[10] = '{A_CTRL,   4'b0001, 32'hFFFF_FF05, A_CTRL,   32'h0000_0005};

        reset  = 1'b1;
        addr   = 32'd0;
        byteen = 4'd0;
        wdata  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk_reg("rst_ctrl",   A_CTRL,   32'd0);
        chk_reg("rst_preset", A_PRESET, 32'd0);
        chk_reg("rst_count",  A_COUNT,  32'd0);
        chk_reg("rst_rsv",    A_RSV,    32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].waddr, vecs[i].be, vecs[i].wdata);
            chk_reg($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reg("rst2_ctrl",  A_CTRL,  32'd0);
        chk_reg("rst2_count", A_COUNT, 32'd0);

        // One-shot, PRESET=3: count 3,2,1,0 with irq after edge 5.
        wr(A_PRESET, 4'hF, 32'd3);
        wr(A_CTRL, 4'hF, 32'h9);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            exp_cnt = (e == 1) ? 32'd0 : 32'd3 - 32'(e - 2);
            chk_reg($sformatf("os_count_e%0d", e), A_COUNT, exp_cnt);
            chk($sformatf("os_irq_e%0d", e), {31'd0, irq}, {31'd0, (e >= 5)});
        end
        repeat (4) @(negedge clk);
        chk_reg("os_ctrl_after", A_CTRL, 32'h8);
        chk("os_irq_held", {31'd0, irq}, 32'd1);
        chk_reg("os_count_hold", A_COUNT, 32'd0);
        wr(A_PRESET, 4'hF, 32'd0);
        chk("os_irq_cleared", {31'd0, irq}, 32'd0);

        // Auto-reload, PRESET=2: pulses after edges 4, 8, 12, 16.
        wr(A_PRESET, 4'hF, 32'd2);
        wr(A_CTRL, 4'hF, 32'hB);
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            chk($sformatf("ar_irq_e%0d", e), {31'd0, irq}, {31'd0, (e % 4 == 0)});
        end
        repeat (2) @(negedge clk);
        wr(A_CTRL, 4'hF, 32'hA);
        chk_reg("ar_stop_count", A_COUNT, 32'd1);
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            chk_reg($sformatf("ar_frozen_%0d", e), A_COUNT, 32'd1);
            chk($sformatf("ar_noirq_%0d", e), {31'd0, irq}, 32'd0);
        end

        // Masked one-shot, PRESET=1, then unmask.
        wr(A_PRESET, 4'hF, 32'd1);
        wr(A_CTRL, 4'hF, 32'h1);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            chk($sformatf("mask_irq_e%0d", e), {31'd0, irq}, 32'd0);
        end
        chk_reg("mask_ctrl", A_CTRL, 32'd0);
        chk_reg("mask_count", A_COUNT, 32'd0);
        wr(A_CTRL, 4'hF, 32'h8);
        chk("unmask_irq", {31'd0, irq}, 32'd1);

        // PRESET=0 behaves as 1; CTRL write in the INT cycle overrides the EN clear.
        wr(A_PRESET, 4'hF, 32'd0);
        chk("p0_irq_clr", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 4'hF, 32'h9);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            chk($sformatf("p0_irq_e%0d", e), {31'd0, irq}, {31'd0, (e == 3)});
        end
        wr(A_CTRL, 4'hF, 32'h9);
        chk_reg("int_bus_wins", A_CTRL, 32'h9);
        chk("int_write_clr", {31'd0, irq}, 32'd0);
        repeat (3) @(negedge clk);
        chk("restart_irq", {31'd0, irq}, 32'd1);

        // Reset asserted mid-count with COUNT=7.
        wr(A_PRESET, 4'hF, 32'd7);
        wr(A_CTRL, 4'hF, 32'h9);
        repeat (2) @(negedge clk);
        chk_reg("mid_count7", A_COUNT, 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reg("mr_ctrl",   A_CTRL,   32'd0);
        chk_reg("mr_preset", A_PRESET, 32'd0);
        chk_reg("mr_count",  A_COUNT,  32'd0);
        chk("mr_irq", {31'd0, irq}, 32'd0);
        repeat (4) @(negedge clk);
        chk_reg("mr_idle_count", A_COUNT, 32'd0);
        chk("mr_idle_irq", {31'd0, irq}, 32'd0);
        wr(A_OUT, 4'hF, 32'hFFFF_FFFF);
        wr(A_OUT + 32'd4, 4'hF, 32'hFFFF_FFFF);
        chk_reg("oor_ctrl",   A_CTRL,   32'd0);
        chk_reg("oor_preset", A_PRESET, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
